// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake on both sides.
// Define PIPE_STAGE_REG_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 64,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy
);

  logic              push;
  logic              pop;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DEST_W-1:0] main_dest_q, main_dest_d;

`ifdef PIPE_STAGE_REG_SKID_EN

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [DEST_W-1:0] skid_dest_q, skid_dest_d;

  assign push = in_valid && in_ready_q;
  assign pop  = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    main_dest_d = main_dest_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    skid_dest_d = skid_dest_q;
    // Flush leaves the payload registers untouched so a discarded entry never shows on out_data.
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_dest_d = in_dest;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
            main_dest_d = in_dest;
          end else if (push) begin
            state_d     = TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
            skid_dest_d = in_dest;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            main_dest_d = skid_dest_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_dest_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_dest_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      main_dest_q <= main_dest_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_dest_q <= skid_dest_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign occupancy = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;

`else

  logic main_valid_q, main_valid_d;

  assign in_ready = !main_valid_q || out_ready;
  assign push     = in_valid && in_ready;
  assign pop      = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_ctrl_d  = main_ctrl_q;
    main_data_d  = main_data_q;
    main_dest_d  = main_dest_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (push) begin
      main_valid_d = 1'b1;
      main_ctrl_d  = in_ctrl;
      main_data_d  = in_data;
      main_dest_d  = in_dest;
    end else if (pop) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      main_data_q  <= '0;
      main_dest_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      main_data_q  <= main_data_d;
      main_dest_q  <= main_dest_d;
    end
  end

  assign out_valid = main_valid_q;
  assign occupancy = {1'b0, main_valid_q};

`endif

  // A bubble must carry no write enables downstream.
  assign out_ctrl = out_valid ? main_ctrl_q : '0;
  assign out_data = main_data_q;
  assign out_dest = main_dest_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg, covering both the default
// single-entry build and the PIPE_STAGE_REG_SKID_EN build.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_dest = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_ctrl;
  logic [63:0] out_data;
  logic [4:0]  out_dest;
  logic [1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(64), .DEST_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_dest(in_dest),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_dest(out_dest),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] c, input logic [63:0] d, input logic [4:0] e);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
    in_dest  = e;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    applyStimulus(1'b0, 2'b00, 64'h0, 5'd0);
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %0h exp 0", out_valid); end
    checks++; if (out_ctrl !== 2'b00) begin errors++; $display("[TB] FAIL rst_ctrl got %0h exp 0", out_ctrl); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("[TB] FAIL rst_data got %0h exp 0", out_data); end
    checks++; if (out_dest !== 5'd0) begin errors++; $display("[TB] FAIL rst_dest got %0h exp 0", out_dest); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL rst_occ got %0d exp 0", occupancy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %0h exp 1", in_ready); end
  endtask

  task automatic test_single_pass();
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b11, 64'h1234, 5'd7);
    step();
    applyStimulus(1'b0, 2'b01, 64'hDEAD, 5'd30);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sp_valid got %0h exp 1", out_valid); end
    checks++; if (out_ctrl !== 2'b11) begin errors++; $display("[TB] FAIL sp_ctrl got %0h exp 3", out_ctrl); end
    checks++; if (out_data !== 64'h1234) begin errors++; $display("[TB] FAIL sp_data got %0h exp 1234", out_data); end
    checks++; if (out_dest !== 5'd7) begin errors++; $display("[TB] FAIL sp_dest got %0d exp 7", out_dest); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL sp_occ got %0d exp 1", occupancy); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sp_valid2 got %0h exp 0", out_valid); end
    checks++; if (out_ctrl !== 2'b00) begin errors++; $display("[TB] FAIL sp_ctrl2 got %0h exp 0", out_ctrl); end
    checks++; if (out_data !== 64'h1234) begin errors++; $display("[TB] FAIL sp_data_hold got %0h exp 1234", out_data); end
  endtask

`ifdef PIPE_STAGE_REG_SKID_EN
  task automatic test_backpressure();
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b01, 64'hA, 5'd1);
    step();
    applyStimulus(1'b1, 2'b10, 64'hB, 5'd2);
    step();
    applyStimulus(1'b0, 2'b11, 64'hDEAD, 5'd31);
    checks++; if (occupancy !== 2'd2) begin errors++; $display("[TB] FAIL bp_occ2 got %0d exp 2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready got %0h exp 0", in_ready); end
    checks++; if (out_data !== 64'hA) begin errors++; $display("[TB] FAIL bp_head got %0h exp A", out_data); end
    step();
    checks++; if (out_data !== 64'hA || out_ctrl !== 2'b01 || out_dest !== 5'd1) begin errors++; $display("[TB] FAIL bp_hold got %0h/%0h/%0d exp A/1/1", out_data, out_ctrl, out_dest); end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 64'hB || out_ctrl !== 2'b10 || out_dest !== 5'd2) begin errors++; $display("[TB] FAIL bp_second got %0h/%0h/%0d exp B/2/2", out_data, out_ctrl, out_dest); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL bp_occ1 got %0d exp 1", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_in_ready2 got %0h exp 1", in_ready); end
    step();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got occ %0d valid %0h exp 0/0", occupancy, out_valid); end
  endtask
`else
  task automatic test_backpressure();
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b01, 64'hA, 5'd1);
    step();
    applyStimulus(1'b1, 2'b10, 64'hD, 5'd4);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ns_in_ready got %0h exp 0", in_ready); end
    step();
    checks++; if (out_data !== 64'hA || out_ctrl !== 2'b01) begin errors++; $display("[TB] FAIL ns_hold got %0h/%0h exp A/1", out_data, out_ctrl); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL ns_occ got %0d exp 1", occupancy); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ns_in_ready2 got %0h exp 1", in_ready); end
    step();
    applyStimulus(1'b0, 2'b11, 64'hDEAD, 5'd31);
    checks++; if (out_data !== 64'hD || out_ctrl !== 2'b10 || out_dest !== 5'd4) begin errors++; $display("[TB] FAIL ns_replace got %0h/%0h/%0d exp D/2/4", out_data, out_ctrl, out_dest); end
    checks++; if (occupancy !== 2'd1 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ns_occ2 got occ %0d valid %0h exp 1/1", occupancy, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ns_drain got %0h exp 0", out_valid); end
  endtask
`endif

  task automatic test_flush();
    logic [1:0] exp_occ;
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b01, 64'hA, 5'd1);
    step();
`ifdef PIPE_STAGE_REG_SKID_EN
    applyStimulus(1'b1, 2'b10, 64'hB, 5'd2);
    step();
    exp_occ = 2'd2;
`else
    exp_occ = 2'd1;
`endif
    checks++; if (occupancy !== exp_occ) begin errors++; $display("[TB] FAIL fl_pre_occ got %0d exp %0d", occupancy, exp_occ); end
    flush = 1'b1;
    out_ready = 1'b1;
    applyStimulus(1'b1, 2'b11, 64'hC, 5'd3);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 2'b11, 64'hC, 5'd3);
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL fl_occ got %0d exp 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fl_valid got %0h exp 0", out_valid); end
    checks++; if (out_ctrl !== 2'b00) begin errors++; $display("[TB] FAIL fl_ctrl got %0h exp 0", out_ctrl); end
    checks++; if (out_data !== 64'hA) begin errors++; $display("[TB] FAIL fl_data got %0h exp A", out_data); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (out_valid !== 1'b0 || out_data === 64'hC) begin errors++; $display("[TB] FAIL fl_stale got valid %0h data %0h exp 0/not C", out_valid, out_data); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = 64'(i);
      applyStimulus(1'b1, d[1:0], d, d[4:0]);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bb_in_ready[%0d] got %0h exp 1", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== d || out_ctrl !== d[1:0] || out_dest !== d[4:0]) begin errors++; $display("[TB] FAIL bb_pop[%0d] got v%0h d%0h c%0h e%0d exp 1/%0h/%0h/%0d", i, out_valid, out_data, out_ctrl, out_dest, d, d[1:0], d[4:0]); end
    end
    applyStimulus(1'b0, 2'b00, 64'h0, 5'd0);
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("[TB] FAIL bb_end got valid %0h occ %0d exp 0/0", out_valid, occupancy); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    applyStimulus(1'b1, 2'b11, 64'hE5, 5'd9);
    step();
    applyStimulus(1'b0, 2'b00, 64'h0, 5'd0);
    checks++; if (occupancy !== 2'd1 || out_data !== 64'hE5) begin errors++; $display("[TB] FAIL ar_pre got occ %0d data %0h exp 1/E5", occupancy, out_data); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_valid got %0h exp 0", out_valid); end
    checks++; if (out_data !== 64'h0) begin errors++; $display("[TB] FAIL ar_data got %0h exp 0", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL ar_occ got %0d exp 0", occupancy); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin errors++; $display("[TB] FAIL ar_stale got valid %0h data %0h exp 0/0", out_valid, out_data); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ar_in_ready got %0h exp 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
